// File: rtl/exe_pkg.sv
// -----------------------------------------------------------------------------
// exe_pkg
// Shared types and constants for the execute-dispatch block.
//   UNIT_*    : unit index of each execution unit in the per-unit vectors
//   reg_t     : architectural register number (16 registers, r0 hard-wired)
//   slot_t    : contents of one dispatch slot (destination, operands, func)
//   reg_mask  : one-hot of a register number, empty for r0
// -----------------------------------------------------------------------------
package exe_pkg;

    localparam int UNIT_ALU = 3;
    localparam int UNIT_LD  = 2;
    localparam int UNIT_MUL = 1;
    localparam int UNIT_DIV = 0;

    localparam int NUM_REGS = 16;

    typedef logic [3:0]  reg_t;
    typedef logic [3:0]  func_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        reg_t  rd;
        word_t op_a;
        word_t op_b;
        func_t func;
    } slot_t;

    // r0 is never tracked, so its mask is empty.
    function automatic logic [NUM_REGS-1:0] reg_mask(input reg_t r);
        reg_mask = '0;
        if (r != '0) begin
            reg_mask[r] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/dispatch_slot.sv
// -----------------------------------------------------------------------------
// dispatch_slot
// One-entry holding register between the dispatcher and one execution unit.
// The slot is refilled in the same cycle it drains, so a back-to-back stream
// into one unit sees no bubble.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : write load_data into the slot this cycle
//   load_data    : instruction to store
//   out_ready    : unit consumes the slot contents this cycle
//   out_valid    : slot holds an instruction
//   out_data     : slot contents (all zero while empty)
// -----------------------------------------------------------------------------
module dispatch_slot
    import exe_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  slot_t load_data,
    input  logic  out_ready,
    output logic  out_valid,
    output slot_t out_data
);

    logic  valid_q, valid_d;
    slot_t data_q,  data_d;

    always_comb begin
        // NOTE: hold-by-default assignments first keep this block latch-free.
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            // Covers both an empty slot and a drain-plus-refill in one cycle.
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
            data_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload is reset along with valid because an empty slot must read as zero.
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/exe_dispatch.sv
// -----------------------------------------------------------------------------
// exe_dispatch
// Routes one decoded instruction per cycle into a one-entry slot per execution
// unit and, optionally, stalls on register hazards using a busy-register
// scoreboard.
//
// Optional feature macro: EXE_DISPATCH_SCOREBOARD_EN
//   defined   -> RAW/WAW stall on busy registers, busy bits set on issue and
//                cleared on write-back
//   undefined -> no hazard stall, busy_regs tied to 0, wb_valid/wb_Rd unused
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid / in_ready        : instruction handshake (in_ready is 0 in reset)
//   in_unit                    : target unit (3 ALU, 2 LD, 1 MUL, 0 DIV)
//   in_Rd, in_Rs1, in_Rs2      : destination / source register numbers
//   in_opA, in_opB, in_func    : operands and unit sub-operation
//   unit_valid / unit_ready    : per-unit slot handshake
//   unit_Rd, unit_opA,
//   unit_opB, unit_func        : packed slot contents, unit k at [k*w +: w]
//   wb_valid, wb_Rd            : write-back completion, retires a busy register
//   busy_regs                  : scoreboard, bit r set while r is pending
// -----------------------------------------------------------------------------
module exe_dispatch
    import exe_pkg::*;
#(
    parameter int NUM_UNITS = 4
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_unit,
    input  logic [3:0]              in_Rd,
    input  logic [3:0]              in_Rs1,
    input  logic [3:0]              in_Rs2,
    input  logic [31:0]             in_opA,
    input  logic [31:0]             in_opB,
    input  logic [3:0]              in_func,
    output logic [NUM_UNITS-1:0]    unit_valid,
    input  logic [NUM_UNITS-1:0]    unit_ready,
    output logic [NUM_UNITS*4-1:0]  unit_Rd,
    output logic [NUM_UNITS*32-1:0] unit_opA,
    output logic [NUM_UNITS*32-1:0] unit_opB,
    output logic [NUM_UNITS*4-1:0]  unit_func,
    input  logic                    wb_valid,
    input  logic [3:0]              wb_Rd,
    output logic [15:0]             busy_regs
);

    slot_t                in_slot;
    slot_t                slot_data [NUM_UNITS];
    logic [NUM_UNITS-1:0] slot_load;
    logic                 target_free;
    logic                 hazard;
    logic                 accept;

    assign in_slot = '{rd: in_Rd, op_a: in_opA, op_b: in_opB, func: in_func};

    // The target slot can take a new instruction if it is empty or drains now.
    assign target_free = ~unit_valid[in_unit] | unit_ready[in_unit];

    // Gating with rst_n keeps in_ready low for the whole reset window.
    assign in_ready = rst_n & target_free & ~hazard;
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < NUM_UNITS; k++) begin : g_slot
        assign slot_load[k] = accept && (in_unit == 2'(k));

        dispatch_slot u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (slot_load[k]),
            .load_data (in_slot),
            .out_ready (unit_ready[k]),
            .out_valid (unit_valid[k]),
            .out_data  (slot_data[k])
        );

        assign unit_Rd  [k*4  +: 4]  = slot_data[k].rd;
        assign unit_opA [k*32 +: 32] = slot_data[k].op_a;
        assign unit_opB [k*32 +: 32] = slot_data[k].op_b;
        assign unit_func[k*4  +: 4]  = slot_data[k].func;
    end

`ifdef EXE_DISPATCH_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d = busy_d & ~reg_mask(wb_Rd);
        end
        // Applied after the clear so a same-cycle issue to the retiring
        // register leaves it busy for the new producer.
        if (accept) begin
            busy_d = busy_d | reg_mask(in_Rd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Destination is checked too (WAW). Write-back in the same cycle does not
    // release the stall; the instruction goes one cycle later.
    assign hazard    = busy_q[in_Rs1] | busy_q[in_Rs2] | busy_q[in_Rd];
    assign busy_regs = busy_q;
`else
    logic unused_wb;

    assign hazard    = 1'b0;
    assign busy_regs = '0;
    assign unused_wb = ^{wb_valid, wb_Rd};
`endif

endmodule

// File: tb/tb_exe_dispatch.sv
// -----------------------------------------------------------------------------
// tb_exe_dispatch
// Directed bench for exe_dispatch. Expected slot contents are queued per unit
// when an instruction is presented and compared when the slot shows it.
// Works with or without EXE_DISPATCH_SCOREBOARD_EN.
// -----------------------------------------------------------------------------
module tb_exe_dispatch;
    import exe_pkg::*;

`ifdef EXE_DISPATCH_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_unit = '0;
    logic [3:0]   in_Rd = '0, in_Rs1 = '0, in_Rs2 = '0;
    logic [31:0]  in_opA = '0, in_opB = '0;
    logic [3:0]   in_func = '0;
    logic [3:0]   unit_valid;
    logic [3:0]   unit_ready = '0;
    logic [15:0]  unit_Rd;
    logic [127:0] unit_opA, unit_opB;
    logic [15:0]  unit_func;
    logic         wb_valid = 1'b0;
    logic [3:0]   wb_Rd = '0;
    logic [15:0]  busy_regs;

    int    n_tests = 0;
    int    n_fail  = 0;
    slot_t exp_q [4][$];

    always #5 clk = ~clk;

    exe_dispatch #(.NUM_UNITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_unit    (in_unit),
        .in_Rd      (in_Rd),
        .in_Rs1     (in_Rs1),
        .in_Rs2     (in_Rs2),
        .in_opA     (in_opA),
        .in_opB     (in_opB),
        .in_func    (in_func),
        .unit_valid (unit_valid),
        .unit_ready (unit_ready),
        .unit_Rd    (unit_Rd),
        .unit_opA   (unit_opA),
        .unit_opB   (unit_opB),
        .unit_func  (unit_func),
        .wb_valid   (wb_valid),
        .wb_Rd      (wb_Rd),
        .busy_regs  (busy_regs)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the negedge; outputs are read there or 1 time unit later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present(input int u, input logic [3:0] rd, input logic [3:0] rs1,
                           input logic [3:0] rs2, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] f);
        in_valid = 1'b1;
        in_unit  = 2'(u);
        in_Rd    = rd;
        in_Rs1   = rs1;
        in_Rs2   = rs2;
        in_opA   = a;
        in_opB   = b;
        in_func  = f;
        #1;
    endtask

    task automatic push_expected();
        exp_q[in_unit].push_back('{rd: in_Rd, op_a: in_opA, op_b: in_opB, func: in_func});
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic retire(input logic [3:0] rd);
        wb_valid = 1'b1;
        wb_Rd    = rd;
        step();
        wb_valid = 1'b0;
    endtask

    // Compare slot k against the oldest expected entry without consuming it.
    task automatic check_slot(input string tag, input int k);
        slot_t e;
        if (exp_q[k].size() == 0) begin
            check({tag, "_queue"}, 128'(exp_q[k].size()), 128'd1);
        end else begin
            e = exp_q[k][0];
            check(tag, {unit_valid[k], unit_Rd[k*4 +: 4], unit_opA[k*32 +: 32],
                        unit_opB[k*32 +: 32], unit_func[k*4 +: 4]},
                  {1'b1, e.rd, e.op_a, e.op_b, e.func});
        end
    endtask

    task automatic drop(input int k);
        slot_t e;
        if (exp_q[k].size() != 0) e = exp_q[k].pop_front();
    endtask

    task automatic check_empty(input string tag, input int k);
        check(tag, {unit_valid[k], unit_Rd[k*4 +: 4], unit_opA[k*32 +: 32],
                    unit_opB[k*32 +: 32], unit_func[k*4 +: 4]}, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset: in_ready must stay low even with a free target ----
        in_valid = 1'b1;
        in_unit  = 2'(UNIT_ALU);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_unit_valid", unit_valid, 4'h0);
        check("rst_busy", busy_regs, 16'h0);
        idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", in_ready, 1'b1);

        // ---- ALU Rd=5, 7/9, unit ready: one-cycle latency, then drain ----
        @(negedge clk);
        unit_ready[UNIT_ALU] = 1'b1;
        present(UNIT_ALU, 4'd5, 4'd1, 4'd2, 32'd7, 32'd9, 4'd3);
        check("alu_ready", in_ready, 1'b1);
        push_expected();
        step();
        idle();
        check_slot("alu_slot", UNIT_ALU);
        check("alu_busy5", busy_regs, SB_EN ? 16'h0020 : 16'h0000);
        step();
        drop(UNIT_ALU);
        check_empty("alu_drained", UNIT_ALU);
        check("alu_busy_hold", busy_regs, SB_EN ? 16'h0020 : 16'h0000);
        retire(4'd5);
        check("alu_busy_retired", busy_regs, 16'h0);

        // ---- MUL full with unit stalled, then same-cycle drain and refill ----
        unit_ready[UNIT_MUL] = 1'b0;
        present(UNIT_MUL, 4'd6, 4'd1, 4'd2, 32'd11, 32'd12, 4'd1);
        push_expected();
        step();
        present(UNIT_MUL, 4'd7, 4'd8, 4'd9, 32'd21, 32'd22, 4'd2);
        check("mul_full_ready", in_ready, 1'b0);
        step();
        check_slot("mul_stable", UNIT_MUL);
        unit_ready[UNIT_MUL] = 1'b1;
        #1;
        check("mul_refill_ready", in_ready, 1'b1);
        push_expected();
        step();
        drop(UNIT_MUL);
        idle();
        check_slot("mul_no_bubble", UNIT_MUL);
        step();
        drop(UNIT_MUL);
        check_empty("mul_drained", UNIT_MUL);
        unit_ready[UNIT_MUL] = 1'b0;
        check("mul_busy", busy_regs, SB_EN ? 16'h00C0 : 16'h0000);
        retire(4'd6);
        retire(4'd7);
        check("mul_busy_retired", busy_regs, 16'h0);

        // ---- LD Rd=3 then ALU reading r3: RAW stall until retire ----
        unit_ready[UNIT_LD]  = 1'b0;
        unit_ready[UNIT_ALU] = 1'b1;
        present(UNIT_LD, 4'd3, 4'd1, 4'd2, 32'd100, 32'd4, 4'd0);
        push_expected();
        step();
        present(UNIT_ALU, 4'd8, 4'd3, 4'd0, 32'd1, 32'd2, 4'd5);
`ifdef EXE_DISPATCH_SCOREBOARD_EN
        check("raw_stall0", in_ready, 1'b0);
        step();
        check("raw_stall1", in_ready, 1'b0);
        wb_valid = 1'b1;
        wb_Rd    = 4'd3;
        #1;
        check("raw_no_bypass", in_ready, 1'b0);
        step();
        wb_valid = 1'b0;
        #1;
        check("raw_release", in_ready, 1'b1);
`else
        check("raw_no_stall", in_ready, 1'b1);
`endif
        push_expected();
        step();
        idle();
        check_slot("raw_alu_slot", UNIT_ALU);
        step();
        drop(UNIT_ALU);
        check_empty("raw_alu_drained", UNIT_ALU);
        check_slot("ld_held", UNIT_LD);
        unit_ready[UNIT_LD] = 1'b1;
        step();
        drop(UNIT_LD);
        check_empty("ld_drained", UNIT_LD);
        unit_ready[UNIT_LD] = 1'b0;
        check("raw_busy8", busy_regs, SB_EN ? 16'h0100 : 16'h0000);
        retire(4'd8);

        // ---- issue Rd=4 while r4 retires in the same cycle: set wins ----
        present(UNIT_ALU, 4'd4, 4'd1, 4'd2, 32'hDEAD_BEEF, 32'h0123_4567, 4'd9);
        wb_valid = 1'b1;
        wb_Rd    = 4'd4;
        push_expected();
        step();
        idle();
        wb_valid = 1'b0;
        check("set_over_clear", busy_regs, SB_EN ? 16'h0010 : 16'h0000);
        check_slot("set_clear_slot", UNIT_ALU);
        step();
        drop(UNIT_ALU);
        retire(4'd4);
        check("set_clear_retired", busy_regs, 16'h0);

        // ---- Rd=0 is never marked busy ----
        present(UNIT_ALU, 4'd0, 4'd0, 4'd0, 32'hFFFF_FFFF, 32'h8000_0000, 4'd15);
        push_expected();
        step();
        idle();
        check("r0_not_busy", busy_regs, 16'h0);
        check_slot("r0_slot", UNIT_ALU);
        step();
        drop(UNIT_ALU);

        // ---- fill all four slots, then asynchronous reset mid-cycle ----
        unit_ready = 4'h0;
        for (int u = 3; u >= 0; u--) begin
            present(u, 4'(9 + (3 - u)), 4'd0, 4'd0, 32'(u * 16 + 1), 32'(u * 16 + 2), 4'(u));
            push_expected();
            step();
        end
        idle();
        check("full_valid", unit_valid, 4'hF);
        check("full_busy", busy_regs, SB_EN ? 16'h1E00 : 16'h0000);
        check_slot("full_div_slot", UNIT_DIV);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", unit_valid, 4'h0);
        check("async_rst_busy", busy_regs, 16'h0);
        check("async_rst_ready", in_ready, 1'b0);
        check("async_rst_opA", unit_opA, '0);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        @(negedge clk);
        rst_n = 1'b1;

        // ---- after reset: reading r9 must not stall (scoreboard was cleared) ----
        present(UNIT_DIV, 4'd13, 4'd9, 4'd10, 32'd144, 32'd12, 4'd6);
        check("post_rst_issue", in_ready, 1'b1);
        push_expected();
        step();
        idle();
        check_slot("post_rst_slot", UNIT_DIV);
        unit_ready[UNIT_DIV] = 1'b1;
        step();
        drop(UNIT_DIV);
        check_empty("post_rst_drained", UNIT_DIV);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
